// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-wide memory access path.
//   mem_size_e    : access size encoding carried on req_size
//   mem_state_e   : mem_access_unit FSM states
//   is_misaligned : alignment rule, also used by the decode-stage exception logic
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Encoding 3 on req_size has no enumerator; it is always rejected.
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } mem_state_e;

    // Byte accesses are always aligned; an illegal size is reported separately.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between a 32-bit memory word and the
// right-justified pipeline data (little-endian lanes).
//   size       in  access size (mem_size_e encoding)
//   sign_ext   in  sign-extend sub-word load data
//   addr_lo    in  byte offset within the word
//   old_word   in  word read from memory
//   store_data in  right-justified store data
//   load_data  out extracted and extended load result
//   store_word out old_word with the target lanes replaced by store_data
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = old_word >> {addr_lo, 3'b000};
        load_data  = shifted;
        store_word = store_data;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                store_word = old_word;
                store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                store_word = old_word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                // Word access: data passes through, sign_ext is irrelevant.
                load_data  = shifted;
                store_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide simulated memory. Turns byte/half/word
// loads and stores into single-word transactions; sub-word stores are done as
// read-modify-write because the memory has no byte enables.
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   req_write/size/signed   request attributes
//   req_addr, req_wdata     byte address, right-justified store data
//   resp_valid              one-cycle completion pulse
//   resp_rdata, resp_err    load result / error, zero unless resp_valid
//   mem_we/addr/wdata       memory command (zero outside RD/WR)
//   mem_rdata, mem_err      combinational memory read data and error flag
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32  // lane logic assumes 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    mem_state_e        state_q, state_d;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              align_err;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_word;

    assign accept    = (state_q == StIdle) && req_valid;
    assign align_err = (req_size == SZ_ILLEGAL) || is_misaligned(req_size, req_addr[1:0]);

    mem_lane_align u_lane_align (
        .size       (size_q),
        .sign_ext   (signed_q),
        .addr_lo    (addr_q[1:0]),
        .old_word   (rdata_q),
        .store_data (wdata_q),
        .load_data  (load_data),
        .store_word (merged_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata_q  <= '0;
                err_q    <= align_err;
            end
            if (state_q == StRd) begin
                rdata_q <= mem_rdata;
                err_q   <= err_q | mem_err;
            end
            if (state_q == StWr) begin
                err_q <= err_q | mem_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (align_err) begin
                        state_d = StResp;
                    end else if (!req_write || (req_size != SZ_WORD)) begin
                        state_d = StRd;
                    end else begin
                        state_d = StWr;
                    end
                end
            end
            // A read error aborts a read-modify-write before anything is written.
            StRd:    state_d = (write_q && !mem_err) ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state so reset drops mem_we without waiting for a clock.
    always_comb begin
        req_ready  = (state_q == StIdle);
        mem_we     = (state_q == StWr);
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = (state_q == StResp);
        resp_err   = 1'b0;
        resp_rdata = '0;
        if ((state_q == StRd) || (state_q == StWr)) begin
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        end
        if (state_q == StWr) begin
            mem_wdata = merged_word;
        end
        if (state_q == StResp) begin
            resp_err = err_q;
            if (!write_q && !err_q) begin
                resp_rdata = load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues requests and pushes the
// reference model's expectation; a monitor checks memory writes and responses.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_err;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    bit          mon_en = 1'b0;
    bit          load_mem = 1'b1;
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];

    mem_access_unit #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word 0x100 (index 0x40) starts as 0x8899AABB; the rest are scrambled.
    function automatic logic [31:0] init_word(input int i);
        logic [31:0] x;
        x = 32'(i) ^ 32'd64;
        return 32'h8899AABB ^ (x * 32'h9E3779B1);
    endfunction

    // Simulated memory: 256 words, error region 0xE00-0xEFF.
    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_err   = (mem_addr[11:8] == 4'hE);

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        end else if (mem_we && !mem_err && !reset) begin
            mem[mem_addr[9:2]] = mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: byte-by-byte view of the request against ref_mem.
    function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output exp_t e);
        int          nb;
        int          off;
        logic        bad;
        logic [31:0] word;
        logic [31:0] val;
        e.rdata = '0; e.err = 1'b0; e.lat = 1; e.wr = 1'b0;
        e.waddr = '0; e.wdata = '0; e.due = 0;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        if (sz == 2'd3 || (off % nb) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
            return;
        end
        bad     = (a[11:8] == 4'hE);
        word    = ref_mem[a[9:2]];
        e.waddr = {a[31:2], 2'b00};
        if (!w) begin
            e.lat = 2;
            e.err = bad;
            if (!bad) begin
                val = '0;
                for (int b = 0; b < nb; b++) val[8*b +: 8] = word[8*(off+b) +: 8];
                if (sg && nb < 4 && val[8*nb-1])
                    for (int b = nb; b < 4; b++) val[8*b +: 8] = 8'hFF;
                e.rdata = val;
            end
        end else if (nb == 4) begin
            e.lat   = 2;
            e.wr    = 1'b1;
            e.wdata = wd;
            e.err   = bad;
            if (!bad) ref_mem[a[9:2]] = wd;
        end else if (bad) begin
            e.lat = 2;
            e.err = 1'b1;
        end else begin
            for (int b = 0; b < nb; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
            e.lat   = 3;
            e.wr    = 1'b1;
            e.wdata = word;
            ref_mem[a[9:2]] = word;
        end
    endfunction

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready got %b expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        model(w, sz, sg, a, wd, e);
        // Accept edge is cycle cyc+1; response is seen at negedge with cyc = accept+lat-1.
        e.due = cyc + e.lat;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) begin
                wr_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h with no request", mem_addr,
                             mem_wdata);
                end else begin
                    check("wr_addr", mem_addr, sb[0].waddr);
                    check("wr_data", mem_wdata, sb[0].wdata);
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: rdata %h err %b with no request", resp_rdata,
                             resp_err);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_rdata", resp_rdata, mon_e.rdata);
                    check("resp_err", 32'(resp_err), 32'(mon_e.err));
                    check("resp_cycle", 32'(cyc), 32'(mon_e.due));
                    check("write_count", 32'(wr_seen), 32'(mon_e.wr));
                end
                wr_seen = 0;
            end else begin
                check("idle_rdata", resp_rdata, 32'h0);
                check("idle_err", 32'(resp_err), 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time got %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        int          r;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        load_mem = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed cases around word 0x100 = 0x8899AABB.
        issue(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h55);
        wait_drain();
        check("mem_after_byte_store", mem[8'h40], 32'h5599AABB);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'hE01, 32'h12);
        issue(1'b1, 2'd1, 1'b1, 32'h1FE, 32'hCAFE8001);
        issue(1'b0, 2'd1, 1'b1, 32'h1FE, 32'h0);
        wait_drain();

        // Reset while the WR cycle of a sub-word store is in progress.
        mon_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h104; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 0; n < 10 && !mem_we; n++) @(negedge clk);
        check("we_before_reset", 32'(mem_we), 32'h1);
        reset = 1'b1;
        #1;
        check("we_during_reset", 32'(mem_we), 32'h0);
        check("addr_during_reset", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'h1);
        check("resp_after_reset", 32'(resp_valid), 32'h0);
        check("mem_unwritten", mem[8'h41], ref_mem[8'h41]);
        wr_seen = 0;
        mon_en  = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 15));
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            sg = 1'($urandom_range(0, 1));
            a  = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom();
            issue(w, sz, sg, a, wd);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the word-wide simulated-memory port: converts MEM-stage load/store requests (byte, halfword, word; signed/unsigned) into single-word memory transactions. Sub-word stores use read-modify-write because the memory has no byte enables. Sits between the pipeline MEM stage and the simulated memory, and owns all alignment checking and byte-lane handling.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width; only 32 is supported
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  MEM stage presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  loads only; sign-extend sub-word data
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or memory error
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data, valid while mem_we = 0
- mem_err  in  1  memory error flag, sampled at the end of RD/WR cycles

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: req_ready = 1. On req_valid, latch write, size, signed, addr and wdata, then:
  - illegal size, or misaligned (half with addr[0] = 1; word with addr[1:0] ≠ 0) -> RESP with err = 1; no memory access
  - load, or store with size < word -> RD
  - word store -> WR
- RD: mem_we = 0, mem_addr = latched aligned address. At the clock edge, capture mem_rdata and mem_err.
  - load -> RESP
  - sub-word store -> WR
- WR: mem_we = 1. mem_wdata is the captured read word with the target lanes replaced by req_wdata (for word stores: req_wdata as-is). At the edge, capture mem_err -> RESP.
- RESP: resp_valid = 1 for one cycle -> IDLE.
  - resp_err = OR of the alignment error and every captured mem_err.
  - A memory error in RD aborts the store: go straight to RESP and skip WR.
- Byte lanes are little-endian: byte k lives at bits [8k+7:8k], selected by addr[1:0]; a halfword at addr[1] occupies bits [16·addr[1]+15 : 16·addr[1]].
- Load extraction: shift the lane down, then zero-extend or sign-extend to 32 bits per req_signed. Word loads ignore req_signed.
- Outside RD/WR: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- A request in any state other than IDLE is not accepted; req_ready = 0.

## Timing
- Reset values:
  - state IDLE, req_ready = 1
  - resp_valid = 0, resp_rdata = 0, resp_err = 0
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
  - all latches 0
- Counting from the accept edge T, resp_valid is high in cycle:
  - error: T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- Minimum issue spacing is 2 cycles (error) to 4 cycles (sub-word store); the next accept can occur in the cycle after RESP.
- mem_we is decoded from state, so an asynchronous reset during WR drops mem_we immediately. A write completes only if its edge occurs with reset low. Reset during RD/RESP discards the request with no response.
- resp_rdata and resp_err are valid only while resp_valid = 1; they hold 0 otherwise.

## Structure
- Package mem_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the FSM state enum
  - a misalignment function shared with the decode-stage exception logic
- Sub-module mem_lane_align: purely combinational.
  - Inputs: size, signed, addr[1:0], old word, store data.
  - Outputs: extended load data, merged store word.
  - The top level keeps the FSM and the latches.

## Test plan
- Memory word 0x100 = 0x8899AABB. Load byte, signed, addr 0x101 -> mem_addr = 0x100; resp at T+2 with rdata 0xFFFFFFAA, err = 0.
- Same word. Load half, unsigned, addr 0x102 -> rdata 0x00008899 at T+2.
- Store byte 0x55 to addr 0x103 -> RD then WR; mem_wdata = 0x5599AABB at T+2; resp at T+3. A following word load of 0x100 returns 0x5599AABB.
- Store word 0xDEADBEEF to 0x200 -> WR in T+1 with no RD; resp at T+2, err = 0.
- Misaligned cases:
  - load word at 0x102 -> resp at T+1 with err = 1, rdata = 0, mem_we never asserted
  - size = 3 -> same response
- Fault and reset cases:
  - mem_err forced high during RD of a sub-word store -> no WR cycle, resp err = 1
  - reset asserted mid-WR -> mem_we falls the same cycle, req_ready = 1 after release
